// File: rtl/tpe_pkg.sv
// Shared definitions for the TPE result drain.
//   RESULT_WIDTH_DEF : default width of one signed PE-tile lane result
//   ACC_WIDTH_DEF    : default width of one signed accumulator
//   tpe_state_e      : drain controller state encoding
//   idx_width()      : index width for a depth, never less than one bit
package tpe_pkg;

  localparam int RESULT_WIDTH_DEF = 20;
  localparam int ACC_WIDTH_DEF    = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } tpe_state_e;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tpe_acc_lane.sv
// One signed accumulator lane: sign-extends a lane result and either loads it
// or adds it with saturation to the signed ACC_WIDTH range.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears the accumulator)
//   load_i    : replace the accumulator with the sign-extended input
//   add_i     : add the sign-extended input with saturation
//   din_i     : signed lane result
//   acc_o     : current accumulator value
//   sat_o     : the add happening this cycle clips (valid while add_i is high)
module tpe_acc_lane
  import tpe_pkg::*;
#(
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    add_i,
  input  logic [RESULT_WIDTH-1:0] din_i,
  output logic [ACC_WIDTH-1:0]    acc_o,
  output logic                    sat_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] din_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf;

  assign din_ext = ACC_WIDTH'($signed(din_i));

  // One guard bit: overflow iff the two top bits of the widened sum disagree;
  // the guard bit then gives the true sign and so the clip direction.
  assign sum = {acc_q[ACC_WIDTH-1], acc_q} + {din_ext[ACC_WIDTH-1], din_ext};
  assign ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = din_ext;
    end else if (add_i) begin
      if (ovf) acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      else     acc_d = sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;
  assign sat_o = add_i && !load_i && ovf;

endmodule

// File: rtl/tpe_result_drain.sv
// Accumulates groups of PE-tile result vectors into N saturating accumulators
// and drains them downstream OUT_LANES accumulators per beat.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : result vector handshake; in_last closes the group
//   result              : N signed lanes of RESULT_WIDTH, lane 0 at LSB
//   out_valid/out_ready : output beat handshake
//   out_data            : OUT_LANES accumulators of the current beat, lowest at LSB
//   out_last            : current beat is the last of the group
//   sat_flag            : sticky, set when any lane add clipped
//
// state | meaning
// ACCUM | accepting vectors; first vector of a group loads, later ones add
// DRAIN | presenting accumulator beats; input is stalled
module tpe_result_drain
  import tpe_pkg::*;
#(
  parameter int N            = 32,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int OUT_LANES    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [RESULT_WIDTH*N-1:0]       result,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ACC_WIDTH*OUT_LANES-1:0]  out_data,
  output logic                            out_last,
  output logic                            sat_flag
);

  localparam int BEATS  = N / OUT_LANES;
  localparam int BEAT_W = idx_width(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  tpe_state_e          state_q;
  logic                first_q;
  logic [BEAT_W-1:0]   beat_q;
  logic                sat_q;

  logic                accept;
  logic                lane_load;
  logic                lane_add;
  logic [N-1:0]        sat_vec;
  logic [ACC_WIDTH*N-1:0] acc_flat;

  // Handshake outputs are forced low during reset, not just after the edge.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == DRAIN) && !rst;

  assign accept    = in_valid && in_ready;
  assign lane_load = accept && first_q;
  assign lane_add  = accept && !first_q;

  for (genvar i = 0; i < N; i++) begin : g_lane
    tpe_acc_lane #(
      .RESULT_WIDTH (RESULT_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load_i (lane_load),
      .add_i  (lane_add),
      .din_i  (result[i*RESULT_WIDTH +: RESULT_WIDTH]),
      .acc_o  (acc_flat[i*ACC_WIDTH +: ACC_WIDTH]),
      .sat_o  (sat_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      first_q <= 1'b1;
      beat_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (|sat_vec) sat_q <= 1'b1;
      case (state_q)
        ACCUM: begin
          if (accept) begin
            first_q <= in_last;
            if (in_last) begin
              state_q <= DRAIN;
              beat_q  <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= ACCUM;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_data = acc_flat[int'(beat_q)*OUT_LANES*ACC_WIDTH +: OUT_LANES*ACC_WIDTH];
  assign out_last = out_valid && (beat_q == LAST_BEAT);
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_tpe_result_drain.sv
module tb_tpe_result_drain;

  localparam int N     = 32;
  localparam int RW    = 20;
  localparam int OL    = 4;
  localparam int BEATS = N / OL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_last;
  logic [RW*N-1:0] result;
  logic          out_ready;

  logic          in_ready_a, out_valid_a, out_last_a, sat_a;
  logic [127:0]  out_data_a;
  logic          in_ready_b, out_valid_b, out_last_b, sat_b;
  logic [95:0]   out_data_b;

  always #5 clk = ~clk;

  tpe_result_drain dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .result    (result),
    .in_ready  (in_ready_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .out_data  (out_data_a),
    .out_last  (out_last_a),
    .sat_flag  (sat_a)
  );

  tpe_result_drain #(.ACC_WIDTH(24)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .result    (result),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .out_data  (out_data_b),
    .out_last  (out_last_b),
    .sat_flag  (sat_b)
  );

  // Reference model: plain integer accumulators for both widths.
  int     lane_v[N];
  longint acc32[N];
  longint acc24[N];
  bit     first_m;
  bit     sat32_m;
  bit     sat24_m;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_add(input longint a, input longint b, input int w, output bit hit);
    longint mx, mn, s;
    mx  = (longint'(1) << (w - 1)) - 1;
    mn  = -mx - 1;
    s   = a + b;
    hit = 1'b0;
    if (s > mx) begin hit = 1'b1; s = mx; end
    else if (s < mn) begin hit = 1'b1; s = mn; end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin acc32[i] = 0; acc24[i] = 0; end
    first_m = 1'b1;
    sat32_m = 1'b0;
    sat24_m = 1'b0;
  endtask

  task automatic model_accept(input bit last);
    bit h;
    for (int i = 0; i < N; i++) begin
      if (first_m) begin
        acc32[i] = lane_v[i];
        acc24[i] = lane_v[i];
      end else begin
        acc32[i] = sat_add(acc32[i], longint'(lane_v[i]), 32, h);
        sat32_m |= h;
        acc24[i] = sat_add(acc24[i], longint'(lane_v[i]), 24, h);
        sat24_m |= h;
      end
    end
    first_m = last;
  endtask

  function automatic logic [127:0] exp_beat(input int k, input bit narrow);
    logic [127:0] e;
    longint v;
    e = '0;
    for (int j = 0; j < OL; j++) begin
      if (narrow) begin
        v = acc24[k*OL + j];
        e[j*24 +: 24] = v[23:0];
      end else begin
        v = acc32[k*OL + j];
        e[j*32 +: 32] = v[31:0];
      end
    end
    return e;
  endfunction

  task automatic drive_vec();
    for (int i = 0; i < N; i++) result[i*RW +: RW] = lane_v[i][RW-1:0];
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) lane_v[i] = v;
  endtask

  task automatic rand_lanes();
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r = RW'($urandom);
      lane_v[i] = int'($signed(r));
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit last);
    int t;
    t = 0;
    drive_vec();
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready_a && t < 50) begin
      @(posedge clk);
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 128'(t < 50), 128'(1));
    @(posedge clk);
    model_accept(last);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, else random ready.
  task automatic drain(input int mode, input int nbeats);
    int k, tick;
    bit rdy, stalled;
    bit pat[4];
    logic [127:0] prev_a;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0; tick = 0; stalled = 1'b0; prev_a = '0;
    while (k < nbeats && tick < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[tick % 4];
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      chk("out_valid_a", 128'(out_valid_a), 128'(1));
      chk("out_valid_b", 128'(out_valid_b), 128'(1));
      chk("in_ready_drain", 128'(in_ready_a), 128'(0));
      chk("out_last_a", 128'(out_last_a), 128'(k == BEATS - 1));
      chk("out_last_b", 128'(out_last_b), 128'(k == BEATS - 1));
      chk("data_a", out_data_a, exp_beat(k, 1'b0));
      chk("data_b", {32'b0, out_data_b}, exp_beat(k, 1'b1));
      chk("sat_a", 128'(sat_a), 128'(sat32_m));
      chk("sat_b", 128'(sat_b), 128'(sat24_m));
      if (stalled) chk("stall_hold", out_data_a, prev_a);
      prev_a  = out_data_a;
      stalled = !rdy;
      @(posedge clk);
      if (rdy) k++;
      tick++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_timeout", 128'(k >= nbeats), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready_a), 128'(0));
    chk("rst_out_valid", 128'(out_valid_a), 128'(0));
    chk("rst_out_valid_b", 128'(out_valid_b), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("rst_sat_a", 128'(sat_a), 128'(0));
    chk("rst_sat_b", 128'(sat_b), 128'(0));
    chk("rst_out_valid2", 128'(out_valid_a), 128'(0));
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_in_ready", 128'(in_ready_a), 128'(1));
    chk("post_rst_out_valid", 128'(out_valid_a), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] e;
    int len;
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; result = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Three-vector group of constant lanes, with a stray in_last mid-group.
    fill(5);
    send(1'b0);
    in_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("last_without_valid", 128'(out_valid_a), 128'(0));
    in_last = 1'b0;
    fill(7);
    send(1'b0);
    fill(-2);
    send(1'b1);
    chk("lat_out_valid", 128'(out_valid_a), 128'(1));
    chk("const_slots", out_data_a, {4{32'd10}});
    drain(0, BEATS);
    chk("back_in_accum", 128'(in_ready_a), 128'(1));
    chk("idle_out_valid", 128'(out_valid_a), 128'(0));

    // Single-vector group with a signed ramp.
    for (int i = 0; i < N; i++) lane_v[i] = i - 16;
    chk("pre_out_valid", 128'(out_valid_a), 128'(0));
    send(1'b1);
    chk("single_lat", 128'(out_valid_a), 128'(1));
    e = {32'hFFFF_FFF3, 32'hFFFF_FFF2, 32'hFFFF_FFF1, 32'hFFFF_FFF0};
    chk("ramp_beat0", out_data_a, e);
    drain(0, BEATS);

    // Stalled drain with the next vector held at the input.
    rand_lanes();
    send(1'b0);
    rand_lanes();
    send(1'b1);
    rand_lanes();
    drive_vec();
    in_valid = 1'b1;
    in_last  = 1'b1;
    drain(1, BEATS);
    send(1'b1);
    drain(1, BEATS);

    // Random groups with random backpressure and idle gaps.
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, 4);
      for (int v = 0; v < len; v++) begin
        rand_lanes();
        send(v == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(2, BEATS);
    end

    // Long groups of a near-full-scale lane 0. 4096 adds stay just inside
    // 32 bits; the 24-bit instance clips after a few adds and stays flagged.
    fill(0);
    lane_v[0] = 524287;
    for (int v = 0; v < 4096; v++) send(v == 4095);
    chk("lane0_32", 128'(out_data_a[31:0]), 128'(32'd2147479552));
    chk("lane0_24", 128'(out_data_b[23:0]), 128'(24'd8388607));
    chk("no_sat_32", 128'(sat_a), 128'(0));
    chk("sat_24", 128'(sat_b), 128'(1));
    drain(0, BEATS);
    rand_lanes();
    send(1'b1);
    chk("sat_24_sticky", 128'(sat_b), 128'(1));
    drain(2, BEATS);
    // 5000 adds exceed 2^31-1, so the 32-bit instance clips as well.
    fill(0);
    lane_v[0] = 524287;
    for (int v = 0; v < 5000; v++) send(v == 4999);
    chk("lane0_32_clip", 128'(out_data_a[31:0]), 128'(32'h7FFF_FFFF));
    chk("sat_32_long", 128'(sat_a), 128'(1));
    drain(0, BEATS);
    do_reset();

    // Reset partway through a drain discards the remaining beats.
    rand_lanes();
    send(1'b0);
    rand_lanes();
    send(1'b1);
    drain(0, 4);
    do_reset();
    @(posedge clk);
    @(negedge clk);
    chk("no_beats_after_rst", 128'(out_valid_a), 128'(0));
    rand_lanes();
    send(1'b0);
    rand_lanes();
    send(1'b1);
    drain(2, BEATS);

    // Reset mid-group: the next group must start fresh.
    rand_lanes();
    send(1'b0);
    do_reset();
    rand_lanes();
    send(1'b1);
    drain(2, BEATS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
